// File: rtl/icache_fetch_port.sv
// Direct-mapped instruction cache sitting between the fetch stage's pipelined
// memory port and a Wishbone read bus. Hits answer one cycle after submit;
// misses refill the whole line and then answer from a capture register.

`ifndef RW
`define RW 16
`endif
`ifndef I_SIZE
`define I_SIZE 32
`endif

module icache_fetch_port #(
    parameter int LINES = 32,
    parameter int WORDS = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [`RW-1:0]     f_addr,
    input  logic               f_submit,
    output logic [`I_SIZE-1:0] f_data,
    output logic               f_ack,
    input  logic               i_invalidate,
    output logic               wb_cyc,
    output logic               wb_stb,
    output logic [`RW-1:0]     wb_adr,
    input  logic [`I_SIZE-1:0] wb_dat_i,
    input  logic               wb_ack,
    output logic               o_busy
);
    localparam int IW     = $clog2(LINES);
    localparam int OW     = $clog2(WORDS);
    localparam int TW     = `RW - IW - OW;
    localparam int DATA_W = `I_SIZE;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;

    state_t state, state_nxt;

    logic [`RW-1:0]    addr_p0;
    logic [LINES-1:0]  valid;
    logic [TW-1:0]     tag_arr  [LINES];
    logic [DATA_W-1:0] data_arr [LINES*WORDS];
    logic [TW-1:0]     tag_p1;
    logic [DATA_W-1:0] data_p1;
    logic [DATA_W-1:0] resp_p1;
    logic [OW-1:0]     beat;
    logic              inv_pend;

    logic [TW-1:0]     q_tag;
    logic [IW-1:0]     q_idx;
    logic [OW-1:0]     q_off;
    logic [IW-1:0]     s_idx;
    logic [IW+OW-1:0]  s_word;
    logic              hit;
    logic              accept;
    logic              beat_ack;
    logic              last_beat;

    // Fields of the latched request and of the incoming submit address.
    assign q_tag  = addr_p0[`RW-1:IW+OW];
    assign q_idx  = addr_p0[IW+OW-1:OW];
    assign q_off  = addr_p0[OW-1:0];
    assign s_idx  = f_addr[IW+OW-1:OW];
    assign s_word = f_addr[IW+OW-1:0];

    // The valid bit is read live so an invalidate at the submit edge is seen.
    assign hit       = valid[q_idx] && (tag_p1 == q_tag);
    assign f_ack     = ((state == LOOKUP) && hit) || (state == RESPOND);
    assign accept    = f_submit && ((state == IDLE) || f_ack);
    assign beat_ack  = (state == REFILL) && wb_ack;
    assign last_beat = beat_ack && (beat == OW'(WORDS - 1));

    assign wb_cyc = (state == REFILL);
    assign wb_stb = (state == REFILL);
    assign wb_adr = {q_tag, q_idx, beat};
    assign o_busy = (state == REFILL) || (state == RESPOND);
    assign f_data = (state == RESPOND) ? resp_p1 : data_p1;

    // Next-state selection; a submit outside IDLE or an ack cycle is ignored.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (f_submit) state_nxt = LOOKUP;
            LOOKUP:  begin
                if (!hit)          state_nxt = REFILL;
                else if (f_submit) state_nxt = LOOKUP;
                else               state_nxt = IDLE;
            end
            REFILL:  if (last_beat) state_nxt = RESPOND;
            RESPOND: state_nxt = f_submit ? LOOKUP : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control state: FSM, valid bits, refill beat counter, pending invalidate.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            valid    <= '0;
            beat     <= '0;
            inv_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            if (i_invalidate)
                valid <= '0;
            else if (last_beat && !inv_pend)
                valid[q_idx] <= 1'b1;
            if (state == LOOKUP)
                beat <= '0;
            else if (beat_ack)
                beat <= beat + OW'(1);
            if (state == RESPOND)
                inv_pend <= 1'b0;
            else if ((state == REFILL) && i_invalidate)
                inv_pend <= 1'b1;
        end
    end

    // Datapath: request latch, synchronous array reads, refill writes.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            addr_p0 <= f_addr;
            tag_p1  <= tag_arr[s_idx];
            data_p1 <= data_arr[s_word];
        end
        if (beat_ack) begin
            data_arr[{q_idx, beat}] <= wb_dat_i;
            if (beat == q_off)
                resp_p1 <= wb_dat_i;
        end
        if (last_beat)
            tag_arr[q_idx] <= q_tag;
    end

endmodule

// File: tb/tb_icache_fetch_port.sv
// Self-checking bench for icache_fetch_port: a Wishbone slave with
// programmable wait states, a line-level cache model (valid + tag per line)
// and scenario tasks followed by a randomized fetch mix.

`ifndef RW
`define RW 16
`endif
`ifndef I_SIZE
`define I_SIZE 32
`endif

module tb_icache_fetch_port;
    localparam int LINES = 32;
    localparam int WORDS = 4;

    logic               i_clk = 1'b0;
    logic               i_rst_n = 1'b0;
    logic [`RW-1:0]     f_addr = '0;
    logic               f_submit = 1'b0;
    logic [`I_SIZE-1:0] f_data;
    logic               f_ack;
    logic               i_invalidate = 1'b0;
    logic               wb_cyc;
    logic               wb_stb;
    logic [`RW-1:0]     wb_adr;
    logic [`I_SIZE-1:0] wb_dat_i;
    logic               wb_ack;
    logic               o_busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ws = 0;
    int wcnt = 0;
    logic late_ack = 1'b0;
    logic [`RW-1:0] beat_q[$];
    int beat_cyc[$];

    // Model: a line holds valid + tag; memory contents are a fixed function.
    bit         mvalid [LINES];
    logic [8:0] mtag   [LINES];

    icache_fetch_port #(.LINES(LINES), .WORDS(WORDS)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .f_addr(f_addr), .f_submit(f_submit),
        .f_data(f_data), .f_ack(f_ack), .i_invalidate(i_invalidate),
        .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
        .wb_ack(wb_ack), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [`I_SIZE-1:0] mem_word(input logic [`RW-1:0] a);
        return {a ^ 16'h5A3C, (~a) + 16'h1234};
    endfunction

    assign wb_dat_i = mem_word(wb_adr);
    assign wb_ack   = (wb_stb && (wcnt == ws)) || late_ack;

    // Slave wait-state counter and bus beat recorder.
    always @(posedge i_clk) begin
        if (wb_stb && !wb_ack) wcnt <= wcnt + 1;
        else                   wcnt <= 0;
        if (wb_cyc && wb_stb && wb_ack) begin
            beat_q.push_back(wb_adr);
            beat_cyc.push_back(cyc);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    task automatic model_clear();
        for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
    endtask

    // One fetch; inv_at: -1 none, 0 with the submit, >=2 during the refill.
    task automatic fetch(input logic [`RW-1:0] a, input int inv_at, input string nm);
        logic [4:0] idx;
        logic [8:0] tg;
        bit hit;
        int lat;
        int exp_lat;
        int c0;
        idx = a[6:2];
        tg  = a[15:7];
        beat_q.delete();
        beat_cyc.delete();
        if (inv_at == 0) model_clear();
        hit = mvalid[idx] && (mtag[idx] == tg);
        exp_lat = hit ? 1 : 2 + WORDS * (ws + 1);
        c0 = cyc;
        f_addr = a;
        f_submit = 1'b1;
        i_invalidate = (inv_at == 0);
        tick();
        f_submit = 1'b0;
        f_addr = 16'($urandom);
        lat = 1;
        i_invalidate = (inv_at == 1);
        while (!f_ack && lat < 400) begin
            tick();
            lat++;
            i_invalidate = (inv_at == lat);
        end
        i_invalidate = 1'b0;
        checks++;
        if (f_ack !== 1'b1) $display("FAIL %s_ack: no ack after %0d cycles", nm, lat);
        checks++;
        if (lat != exp_lat) begin
            failures++;
            $display("FAIL %s_latency: got %0d expected %0d", nm, lat, exp_lat);
        end
        if (f_ack !== 1'b1) failures++;
        checks++;
        if (f_data !== mem_word(a)) begin
            failures++;
            $display("FAIL %s_data: got %h expected %h", nm, f_data, mem_word(a));
        end
        checks++;
        if (o_busy !== !hit) begin
            failures++;
            $display("FAIL %s_busy: got %b expected %b", nm, o_busy, !hit);
        end
        checks++;
        if (beat_q.size() != (hit ? 0 : WORDS)) begin
            failures++;
            $display("FAIL %s_beats: got %0d beats expected %0d", nm, beat_q.size(), hit ? 0 : WORDS);
        end else if (!hit) begin
            for (int k = 0; k < WORDS; k++) begin
                checks++;
                if (beat_q[k] !== {a[15:2], 2'(k)} || beat_cyc[k] != c0 + 2 + k * (ws + 1) + ws) begin
                    failures++;
                    $display("FAIL %s_beat%0d: got adr %h cycle %0d expected adr %h cycle %0d", nm, k,
                             beat_q[k], beat_cyc[k] - c0, {a[15:2], 2'(k)}, 2 + k * (ws + 1) + ws);
                end
            end
        end
        if (!hit) begin
            if (inv_at == 1) model_clear();
            mtag[idx] = tg;
            if (inv_at >= 2 && inv_at < exp_lat) model_clear();
            else mvalid[idx] = 1'b1;
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if ({f_ack, wb_cyc, wb_stb, o_busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs: got ack/cyc/stb/busy=%b expected 0000",
                     {f_ack, wb_cyc, wb_stb, o_busy});
        end
        i_rst_n = 1'b1;
        tick();
        checks++;
        if ({f_ack, wb_cyc, o_busy} !== 3'b000) begin
            failures++;
            $display("FAIL reset_release: got ack/cyc/busy=%b expected 000", {f_ack, wb_cyc, o_busy});
        end
        model_clear();
    endtask

    task automatic test_cold_miss();
        ws = 0;
        fetch(16'h0002, -1, "cold_miss");
    endtask

    task automatic test_hit();
        fetch(16'h0001, -1, "hit");
    endtask

    task automatic test_back_to_back();
        beat_q.delete();
        f_addr = 16'h0000;
        f_submit = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (f_ack !== 1'b1 || f_data !== mem_word(16'(k))) begin
                failures++;
                $display("FAIL b2b_ack%0d: got ack=%b data=%h expected ack=1 data=%h",
                         k, f_ack, f_data, mem_word(16'(k)));
            end
            if (k < 3) begin
                f_addr = 16'(k + 1);
                f_submit = 1'b1;
            end else begin
                f_submit = 1'b0;
            end
            tick();
        end
        checks++;
        if (f_ack !== 1'b0 || beat_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_tail: got ack=%b beats=%0d expected ack=0 beats=0", f_ack, beat_q.size());
        end
    endtask

    task automatic test_alias();
        fetch(16'h0080, -1, "alias_fill");
        fetch(16'h0000, -1, "alias_back");
    endtask

    task automatic test_invalidate();
        fetch(16'h0000, -1, "inv_prime");
        i_invalidate = 1'b1;
        tick();
        i_invalidate = 1'b0;
        model_clear();
        fetch(16'h0000, -1, "inv_pulse");
        fetch(16'h0000, 0, "inv_with_submit");
    endtask

    task automatic test_inv_mid_refill();
        ws = 2;
        fetch(16'h0004, 5, "inv_refill");
        fetch(16'h0004, -1, "inv_refill_again");
        ws = 0;
    endtask

    task automatic test_reset_mid_refill();
        ws = 0;
        f_addr = 16'h0008;
        f_submit = 1'b1;
        tick();
        f_submit = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (wb_cyc !== 1'b1 || wb_adr !== 16'h000A) begin
            failures++;
            $display("FAIL rst_refill_beat2: got cyc=%b adr=%h expected cyc=1 adr=000a", wb_cyc, wb_adr);
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({wb_cyc, wb_stb, o_busy, f_ack} !== 4'b0000) begin
            failures++;
            $display("FAIL rst_refill_release: got cyc/stb/busy/ack=%b expected 0000",
                     {wb_cyc, wb_stb, o_busy, f_ack});
        end
        late_ack = 1'b1;
        tick();
        tick();
        i_rst_n = 1'b1;
        tick();
        late_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (f_ack !== 1'b0 || wb_cyc !== 1'b0) begin
                failures++;
                $display("FAIL rst_refill_quiet%0d: got ack=%b cyc=%b expected 0 0", k, f_ack, wb_cyc);
            end
            tick();
        end
        model_clear();
        fetch(16'h0000, -1, "rst_refill_after");
    endtask

    task automatic test_random();
        logic [`RW-1:0] a;
        int inv;
        for (int n = 0; n < 80; n++) begin
            ws  = $urandom_range(0, 2);
            a   = 16'(($urandom_range(0, 1) << 7) | $urandom_range(0, 127));
            inv = ($urandom_range(0, 9) == 0) ? 0 : -1;
            fetch(a, inv, "random");
            if ($urandom_range(0, 2) == 0) begin
                tick();
                if ($urandom_range(0, 1) == 0) tick();
            end
        end
        ws = 0;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_back_to_back();
        test_alias();
        test_invalidate();
        test_inv_mid_refill();
        test_reset_mid_refill();
        test_random();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
